// File: rtl/fetch_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_responder : PC-to-imem fetch handshake with freeze and flush discard
// Revision 1.0
// ---------------------------------------------------------------------------
module fetch_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc,
   input  logic                  fetch_en,
   input  logic                  flush,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instr_valid,
   output logic                  freeze
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  w_load_addr;
   logic                  w_deliver;
   logic                  w_freeze;
   logic                  r_mem_req;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_instruction;
   logic                  r_instr_valid;

   always_comb begin
      w_next      = r_state;
      w_load_addr = 1'b0;
      w_deliver   = 1'b0;
      w_freeze    = 1'b0;
      case (r_state)
         IDLE: begin
            w_freeze = fetch_en & ~flush;
            if (fetch_en && !flush) begin
               w_next      = WAIT;
               w_load_addr = 1'b1;
            end
         end
         WAIT: begin
            w_freeze = ~(mem_ready | flush);
            if (mem_ready) begin
               // flush beats a same-cycle mem_ready: the word is dropped
               w_next    = IDLE;
               w_deliver = ~flush;
            end else if (flush) begin
               w_next = DISCARD;
            end
         end
         DISCARD: begin
            w_freeze = ~flush;
            if (mem_ready) begin
               w_next = IDLE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
      if (!rst) begin
         w_freeze = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= '0;
         r_instruction <= '0;
         r_instr_valid <= 1'b0;
      end else begin
         r_state       <= w_next;
         // the memory request is held for as long as a transaction is open
         r_mem_req     <= (w_next != IDLE);
         r_instr_valid <= w_deliver;
         if (w_load_addr) begin
            r_mem_addr <= pc;
         end
         if (w_deliver) begin
            r_instruction <= mem_rdata;
         end
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign instruction = r_instruction;
   assign instr_valid = r_instr_valid;
   assign freeze      = w_freeze;

endmodule
`default_nettype wire

// File: tb/tb_fetch_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_responder : randomized transaction bench with delivery scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_fetch_responder;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [AW-1:0] pc = '0;
   logic          fetch_en = 1'b0;
   logic          flush = 1'b0;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic [DW-1:0] instruction;
   logic          instr_valid;
   logic          freeze;

   fetch_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en), .flush(flush),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .instruction(instruction),
      .instr_valid(instr_valid), .freeze(freeze)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad = 0;
   int            cyc_cnt = 0;
   logic [DW-1:0] exp_last = '0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // memory content: a fixed scramble of the address
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // monitor: every delivery must match the oldest expected word, on time
   always @(negedge clk) begin
      if (!rst) begin
         exp_last = '0;
      end else if (instr_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: got instruction %h expected no delivery", instruction);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("instruction", instruction, e.data);
            chk("valid_cycle", cyc_cnt, e.cyc);
            exp_last = e.data;
         end
      end else begin
         chk("instruction_hold", instruction, exp_last);
      end
   end

   // one clock cycle: drive just after posedge, check at negedge
   task automatic cycle(input logic fe, input logic fl, input logic rdy,
                        input logic [AW-1:0] p, input logic [DW-1:0] rd,
                        input logic e_req, input logic chk_addr,
                        input logic [AW-1:0] e_addr, input logic e_frz);
      fetch_en  = fe;
      flush     = fl;
      mem_ready = rdy;
      pc        = p;
      mem_rdata = rd;
      @(negedge clk);
      chk("mem_req", 32'(mem_req), 32'(e_req));
      if (chk_addr) chk("mem_addr", mem_addr, e_addr);
      chk("freeze", 32'(freeze), 32'(e_frz));
      @(posedge clk);
      #1;
   endtask

   // one fetch; memory answers after k wait cycles; flush in wait cycle fl_at (-1: none)
   task automatic do_fetch(input logic [AW-1:0] addr, input int k, input int fl_at);
      bit   flushed = 0;
      logic rdy, fl, frz;
      cycle(1'b1, 1'b0, 1'b0, addr, $urandom, 1'b0, 1'b0, '0, 1'b1);
      for (int i = 0; i <= k; i++) begin
         rdy = (i == k);
         fl  = (i == fl_at) || (flushed && ($urandom_range(0, 2) == 0));
         frz = flushed ? !fl : !(rdy || fl);
         if (rdy && !flushed && !fl) q.push_back('{mem_word(addr), cyc_cnt + 1});
         cycle(1'($urandom_range(0, 1)), fl, rdy, $urandom,
               rdy ? mem_word(addr) : $urandom, 1'b1, 1'b1, addr, frz);
         if (fl) flushed = 1;
      end
   endtask

   // idle cycles that must not start a fetch
   task automatic gap(input int n);
      logic fe, fl;
      for (int i = 0; i < n; i++) begin
         fe = 1'($urandom_range(0, 1));
         fl = fe ? 1'b1 : 1'($urandom_range(0, 1));
         cycle(fe, fl, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0, 1'b0, '0, 1'b0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_instruction"}, instruction, 32'd0);
      chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_freeze"}, 32'(freeze), 32'd0);
   endtask

   initial begin
      int k, fl_at;
      fetch_en = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      #1 rst = 1'b1;
      fetch_en = 1'b0;
      @(posedge clk);
      #1;

      gap(5);
      do_fetch(32'h00, 0, -1);
      do_fetch(32'h04, 0, -1);
      gap(1);
      do_fetch(32'h10, 3, -1);
      gap(2);
      do_fetch(32'h20, 3, 1);
      do_fetch(32'h40, 0, -1);
      do_fetch(32'h50, 2, 2);
      gap(1);
      do_fetch(32'h60, 1, 0);
      gap(1);

      // asynchronous reset in the middle of a WAIT
      cycle(1'b1, 1'b0, 1'b0, 32'h70, '0, 1'b0, 1'b0, '0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 32'h74, '0, 1'b1, 1'b1, 32'h70, 1'b1);
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      #1;
      rst = 1'b1;
      fetch_en = 1'b0;
      @(posedge clk);
      #1;
      do_fetch(32'h80, 2, -1);
      gap(1);

      for (int t = 0; t < 300; t++) begin
         k     = $urandom_range(0, 5);
         fl_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, k)) : -1;
         do_fetch({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, k, fl_at);
         gap($urandom_range(0, 3));
      end

      gap(4);
      chk("scoreboard_drain", q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_responder.md
# fetch_responder

Instruction-fetch responder between the PC register and a variable-latency instruction memory. Each cycle it samples the current `pc`, issues one request per instruction on a req/ready memory port, and returns the fetched word with a one-cycle valid pulse. While a fetch is outstanding it drives `freeze` back to the PC's load control. On a taken branch (`flush`) it lets the PC load the branch target and discards the in-flight word.

## Interface
- ADDR_WIDTH, 32, width of `pc` and `mem_addr` (matches the ISA address length)
- DATA_WIDTH, 32, instruction word width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- pc  in  ADDR_WIDTH  current PC register output
- fetch_en  in  1  pipeline requests the instruction at `pc`
- flush  in  1  branch taken this cycle; abandon the current fetch
- mem_req  out  1  memory request, registered
- mem_addr  out  ADDR_WIDTH  request address, registered, stable while `mem_req`=1
- mem_ready  in  1  memory has `mem_rdata` valid; sampled only while `mem_req`=1
- mem_rdata  in  DATA_WIDTH  returned instruction
- instruction  out  DATA_WIDTH  last delivered instruction, registered, holds between deliveries
- instr_valid  out  1  one-cycle pulse: `instruction` is new
- freeze  out  1  to PC load enable (PC loads when `freeze`=0), combinational

## Operation
- States: IDLE, WAIT, DISCARD.
- IDLE:
  - fetch_en=1, flush=0: at the edge, mem_addr<=pc, mem_req<=1, go to WAIT.
  - Otherwise stay in IDLE, mem_req<=0.
- WAIT:
  - mem_req stays 1 and mem_addr is unchanged.
  - mem_ready=1, flush=0: instruction<=mem_rdata, instr_valid<=1, mem_req<=0, go to IDLE.
  - mem_ready=1, flush=1: drop the data, instr_valid stays 0, mem_req<=0, go to IDLE.
  - mem_ready=0, flush=1: go to DISCARD. The memory transaction cannot be aborted.
  - mem_ready=0, flush=0: stay in WAIT.
- DISCARD:
  - mem_req stays 1 until mem_ready.
  - On mem_ready: drop the data, mem_req<=0, go to IDLE.
  - A flush in DISCARD keeps the state.
- freeze (combinational):
  - In IDLE: fetch_en & ~flush.
  - In WAIT: ~(mem_ready | flush).
  - In DISCARD: ~flush.
  - Forced to 0 while rst=0.
- PC coordination: freeze is low exactly in the cycle the fetch completes. The PC advances to pc+4 at the same edge that latches `instruction`.
- Flush coordination: freeze is low in every flush cycle, so the PC always accepts the branch target on a flush.
- instr_valid never rises for a word whose request precedes a flush.
- At most one request is outstanding. No new request is issued before the previous mem_ready has been seen.

## Timing
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - mem_req=0, mem_addr=0, instruction=0, instr_valid=0, freeze=0.
  - Reset mid-transaction abandons the request without waiting for mem_ready. The memory must tolerate mem_req dropping.
- Latency, measured from the IDLE cycle with fetch_en=1, for a memory answering in k cycles (k=0 means mem_ready high in the first WAIT cycle):
  - instr_valid is high k+2 cycles later.
  - Back-to-back throughput is one instruction per k+2 cycles.
- instr_valid is registered and lasts exactly one cycle per accepted fetch.
- mem_addr changes only on the IDLE-to-WAIT edge.
- Simultaneous mem_ready and flush in WAIT: flush wins and the data is dropped.
- fetch_en deasserted while in WAIT or DISCARD has no effect; the transaction completes.

## Test plan
- Zero-wait memory, pc=0x00 then 0x04, fetch_en=1 → mem_addr 0x00 then 0x04; instr_valid pulses on cycles 2 and 4 with the words from memory; freeze low only in the WAIT cycles.
- Memory with 3 wait cycles, pc=0x10 → mem_req high for 4 cycles with mem_addr=0x10; freeze high 4 cycles; instruction=mem_rdata and instr_valid pulse 1 cycle after mem_ready.
- flush in the 2nd WAIT cycle (mem_ready 2 cycles later) → freeze=0 in the flush cycle; state goes to DISCARD; mem_req held until mem_ready; no instr_valid. Next fetch uses the branch target, e.g. 0x40.
- mem_ready and flush in the same WAIT cycle → no instr_valid; `instruction` unchanged; IDLE next cycle.
- rst pulled low in WAIT → mem_req, instr_valid and freeze are 0 immediately. After release, the first fetch proceeds normally from the current `pc`.
- fetch_en=0 for 5 cycles in IDLE → mem_req=0, freeze=0, no instr_valid.
